// File: rtl/collect_2x1_simple_seq.sv
// rtl/collect_2x1_simple_seq.sv - two-input to one-output word collector with registered output
// Optional feature macro: COLLECT_SUM_EN (cmd 11 loads low+high in one cycle instead of serializing)

module collect_2x1_simple_seq #(
    parameter int DATA_WIDTH    = 32,
    parameter int COMMAND_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              i_valid,
    input  logic [2*DATA_WIDTH-1:0] i_data_bus,
    output logic [1:0]              o_ready,
    output logic                    o_valid,
    output logic [DATA_WIDTH-1:0]   o_data_bus,
    input  logic                    i_ready,
    input  logic                    i_en,
    input  logic [COMMAND_WIDTH-1:0] i_cmd
);

    localparam logic [COMMAND_WIDTH-1:0] CMD_LOW  = COMMAND_WIDTH'(2'b01);
    localparam logic [COMMAND_WIDTH-1:0] CMD_HIGH = COMMAND_WIDTH'(2'b10);
    localparam logic [COMMAND_WIDTH-1:0] CMD_BOTH = COMMAND_WIDTH'(2'b11);

    typedef enum logic {
        S_IDLE      = 1'b0,
        S_SEND_HIGH = 1'b1
    } state_t;

    // Which word (if any) the output register captures this cycle.
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_LOW  = 2'd1,
        SEL_HIGH = 2'd2,
        SEL_SUM  = 2'd3
    } sel_t;

    state_t                  state_q;
    state_t                  state_d;
    logic                    o_valid_q;
    logic                    o_valid_d;
    logic [DATA_WIDTH-1:0]   o_data_q;
    logic [DATA_WIDTH-1:0]   o_data_d;

    logic [DATA_WIDTH-1:0]   data_low;
    logic [DATA_WIDTH-1:0]   data_high;
    logic [DATA_WIDTH-1:0]   word_sel;
    logic                    slot_free;
    logic                    start_ok;
    logic                    cmd_low;
    logic                    cmd_high;
    logic                    cmd_both;
    logic                    both_valid;
    logic [1:0]              ready_d;
    sel_t                    load_sel;

    assign data_low   = i_data_bus[DATA_WIDTH-1:0];
    assign data_high  = i_data_bus[2*DATA_WIDTH-1:DATA_WIDTH];

    // The output slot can take a new word when empty or being drained this cycle.
    assign slot_free  = !o_valid_q | i_ready;
    assign start_ok   = (state_q == S_IDLE) & i_en & slot_free;
    assign cmd_low    = (i_cmd == CMD_LOW);
    assign cmd_high   = (i_cmd == CMD_HIGH);
    assign cmd_both   = (i_cmd == CMD_BOTH);
    assign both_valid = (i_valid == 2'b11);

    // State register: async reset abandons any pending high word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: only a serialized cmd 11 ever leaves IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
`ifndef COLLECT_SUM_EN
                if (start_ok && cmd_both && both_valid) begin
                    state_d = S_SEND_HIGH;
                end
`endif
            end
            S_SEND_HIGH: begin
                if (slot_free && i_valid[1]) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: per-input accepts and load selection, all gated off in reset.
    always_comb begin
        ready_d  = 2'b00;
        load_sel = SEL_NONE;
        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        if (cmd_low && i_valid[0]) begin
                            ready_d  = 2'b01;
                            load_sel = SEL_LOW;
                        end else if (cmd_high && i_valid[1]) begin
                            ready_d  = 2'b10;
                            load_sel = SEL_HIGH;
                        end else if (cmd_both && both_valid) begin
`ifdef COLLECT_SUM_EN
                            ready_d  = 2'b11;
                            load_sel = SEL_SUM;
`else
                            ready_d  = 2'b01;
                            load_sel = SEL_LOW;
`endif
                        end
                    end
                end
                S_SEND_HIGH: begin
                    // Gated by i_valid[1] so o_ready never leads its valid.
                    if (slot_free && i_valid[1]) begin
                        ready_d  = 2'b10;
                        load_sel = SEL_HIGH;
                    end
                end
                default: begin
                    ready_d  = 2'b00;
                    load_sel = SEL_NONE;
                end
            endcase
        end
    end

    // Word mux: unselected cycles produce zero dummy data.
    always_comb begin
        word_sel = '0;
        case (load_sel)
            SEL_LOW:  word_sel = data_low;
            SEL_HIGH: word_sel = data_high;
`ifdef COLLECT_SUM_EN
            SEL_SUM:  word_sel = data_low + data_high;
`endif
            default:  word_sel = '0;
        endcase
    end

    // Output slot next-state: hold while stalled, otherwise load or clear.
    always_comb begin
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        if (slot_free) begin
            o_valid_d = (load_sel != SEL_NONE);
            o_data_d  = word_sel;
        end
    end

    // Output slot register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
        end else begin
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
        end
    end

    assign o_ready    = ready_d;
    assign o_valid    = o_valid_q;
    assign o_data_bus = o_data_q;

    // Upstream must keep the high word offered until it is taken.
    property p_high_held;
        @(posedge clk) disable iff (rst) (state_q == S_SEND_HIGH) |-> i_valid[1];
    endproperty
    a_high_held: assert property (p_high_held);

endmodule

// File: doc/collect_2x1_simple_seq.md
COLLECT_2X1_SIMPLE_SEQ -- requirements
Module: collect_2x1_simple_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of one data word.
REQ-002 SHALL have parameter COMMAND_WIDTH, default 2, width of i_cmd.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port i_valid, input, 2, per-input valid; bit 0 = low input, bit 1 = high input.
REQ-006 SHALL have port i_data_bus, input, 2*DATA_WIDTH, {i_data_high, i_data_low}; low = [DATA_WIDTH-1:0].
REQ-007 SHALL have port o_ready, output, 2, per-input accept; transfer on input k when i_valid[k] & o_ready[k].
REQ-008 SHALL have port o_valid, output, 1, registered output valid.
REQ-009 SHALL have port o_data_bus, output, DATA_WIDTH, registered output word.
REQ-010 SHALL have port i_ready, input, 1, downstream ready; output transfer when o_valid & i_ready.
REQ-011 SHALL have port i_en, input, 1, enables starting new transactions.
REQ-012 SHALL have port i_cmd, input, COMMAND_WIDTH: 00 none, 01 collect low, 10 collect high, 11 collect both.

Function
REQ-013 SHALL define slot_free = !o_valid | i_ready; the output register loads only when slot_free.
REQ-014 SHALL implement FSM states IDLE and SEND_HIGH.
REQ-015 IDLE, i_en=1, slot_free, cmd 01, i_valid[0]=1: SHALL assert o_ready[0], load i_data_low next edge, stay IDLE.
REQ-016 IDLE, i_en=1, slot_free, cmd 10, i_valid[1]=1: SHALL assert o_ready[1], load i_data_high next edge, stay IDLE.
REQ-017 IDLE, i_en=1, slot_free, cmd 11, i_valid=11: SHALL assert o_ready[0] only, load i_data_low, go to SEND_HIGH; with only one input valid, no accept.
REQ-018 SEND_HIGH, slot_free: SHALL assert o_ready[1], load i_data_high, return to IDLE; i_cmd and i_en ignored in SEND_HIGH; i_valid[1] SHALL remain high (upstream rule, checked by assertion).
REQ-019 SHALL drive o_ready combinationally from state, i_en, i_cmd, i_valid, slot_free; o_ready[k] never asserted while i_valid[k]=0.
REQ-020 cmd 00, i_en=0, or slot not free in IDLE: SHALL assert no o_ready and load nothing.
REQ-021 Latency SHALL be 1 cycle from input accept to o_valid; throughput 1 word/cycle with i_ready held 1.
REQ-022 Slot free and nothing loaded: SHALL clear o_valid to 0 and o_data_bus to all zeros (dummy data).
REQ-023 o_valid=1 and i_ready=0: SHALL hold o_valid and o_data_bus stable.
REQ-024 Simultaneous output drain and new load in one cycle SHALL keep o_valid=1 with new data (no bubble).

Reset
REQ-025 rst=1 SHALL asynchronously force state IDLE, o_valid=0, o_data_bus=0.
REQ-026 rst=1 SHALL force o_ready=2'b00 combinationally.
REQ-027 Reset mid-operation (incl. SEND_HIGH) SHALL abandon pending high word; no output after release until a new accept.

Configuration
REQ-028 Macro COLLECT_SUM_EN SHALL be the single compile-time option.
REQ-029 With COLLECT_SUM_EN defined, cmd 11 with i_valid=11 in IDLE SHALL assert o_ready=11 and load low+high (modulo 2^DATA_WIDTH, carry dropped) in one cycle; SEND_HIGH never entered.
REQ-030 Without COLLECT_SUM_EN, cmd 11 SHALL serialize low then high per REQ-017/018.

Verification
REQ-031 Reset: rst pulse mid-cycle -> o_valid=0, o_data_bus=0, o_ready=00 immediately, before next clk edge.
REQ-032 cmd 01, i_valid=01, low=0x11, i_ready=1 -> o_ready=01; next cycle o_valid=1, o_data_bus=0x11; then 0.
REQ-033 cmd 11, i_valid=11, low=0xA, high=0xB, i_ready=1 (no macro) -> o_data_bus 0xA then 0xB on consecutive cycles; o_ready 01 then 10.
REQ-034 Same as REQ-033 with i_ready=0 for 3 cycles after first word -> 0xA held 3 cycles, o_ready=00, then 0xB.
REQ-035 COLLECT_SUM_EN, cmd 11, low=0xFFFFFFFF, high=0x2 -> o_ready=11; next cycle single word 0x00000001.
REQ-036 i_en=0 or cmd 00 with i_valid=11 for 4 cycles -> o_ready=00, o_valid=0 throughout.
